nn_frame_sequencer: RTL and testbench

Controller that sits in front of `neural_network` and sequences it frame by frame. It accepts a serial pixel stream (camera/UART side) and fills a 784-entry frame buffer that drives the network's `img` array. It then raises the network's `enable`, waits for `NN_done`, and reports the classified digit through a one-cycle result strobe. It also detects malformed frames and hung inferences.

---
 rtl/nn_frame_sequencer_if.sv | 13 +
 rtl/nn_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_nn_frame_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_frame_sequencer_if.sv
`timescale 1ns/1ps
// Serial pixel stream between a camera/UART source and the frame sequencer.
// Latency: none, plain wires.
// Backpressure: the source holds pix_valid/pix_data/pix_last until pix_ready.
interface nn_frame_sequencer_if;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_data;
   logic       pix_last;

   modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
   modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/nn_frame_sequencer.sv
`timescale 1ns/1ps
// Buffers one 28x28 frame from a pixel stream, runs the network on it and reports the digit.
// Latency: start enable 2 cycles after the last pixel, result strobe 2 cycles after the done edge.
// Backpressure: pix_ready is high only while loading; the stream stalls during inference and report.
module nn_frame_sequencer #(
   parameter int NPIX           = 784,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                 clk,
   input  logic                 reset,
   nn_frame_sequencer_if.slave  pix,
   output logic signed [7:0]    img [0:NPIX-1],
   output logic                 nn_enable,
   input  logic                 nn_done,
   input  logic [7:0]           nn_digit,
   output logic                 result_valid,
   output logic [7:0]           result_digit,
   output logic                 result_err,
   output logic                 busy
);

   localparam int IDX_W = $clog2(NPIX);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_REPORT} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             armed_q;
   logic             nn_done_d;
   logic             rise_q;
   logic             tmo_q;
   logic             nn_enable_q;
   logic             result_valid_q;
   logic [7:0]       result_digit_q;
   logic             result_err_q;
   logic             busy_q;
   logic             pix_fire;

   // Ready depends on state alone, so there is no path from pix_valid back to pix_ready.
   assign pix.pix_ready = (state_q == S_LOAD);
   assign pix_fire      = pix.pix_valid && (state_q == S_LOAD);

   assign nn_enable    = nn_enable_q;
   assign result_valid = result_valid_q;
   assign result_digit = result_digit_q;
   assign result_err   = result_err_q;
   assign busy         = busy_q;

   // Frame buffer: halve each grey level so the signed network input stays non-negative.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NPIX; i++) img[i] <= '0;
      end else if (pix_fire) begin
         img[idx_q] <= {1'b0, pix.pix_data[7:1]};
      end
   end

   // Sequencer FSM with registered outputs, done-edge detector and inference watchdog.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_LOAD;
         idx_q          <= '0;
         cnt_q          <= '0;
         armed_q        <= 1'b0;
         nn_done_d      <= 1'b0;
         rise_q         <= 1'b0;
         tmo_q          <= 1'b0;
         nn_enable_q    <= 1'b0;
         result_valid_q <= 1'b0;
         result_digit_q <= 8'h00;
         result_err_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         nn_done_d      <= nn_done;
         // Edges are only armed inside WAIT, so a done level left over from before START is ignored.
         rise_q         <= (state_q == S_WAIT) && nn_done && !nn_done_d;
         tmo_q          <= (state_q == S_WAIT) && (cnt_q == CNT_LAST);
         result_valid_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (pix_fire) begin
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_START;
                  end else if (pix.pix_last) begin
                     idx_q          <= '0;
                     busy_q         <= 1'b1;
                     result_valid_q <= 1'b1;
                     result_err_q   <= 1'b1;
                     result_digit_q <= 8'hFF;
                     state_q        <= S_REPORT;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            S_START: begin
               nn_enable_q <= 1'b1;
               cnt_q       <= '0;
               armed_q     <= 1'b0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               // The count starts one cycle late so a timeout lands with the same
               // two-stage latency as a done edge (detect, then report).
               armed_q <= 1'b1;
               if (armed_q) cnt_q <= cnt_q + CNT_W'(1);
               if (rise_q) begin
                  nn_enable_q    <= 1'b0;
                  result_valid_q <= 1'b1;
                  result_err_q   <= 1'b0;
                  result_digit_q <= nn_digit;
                  state_q        <= S_REPORT;
               end else if (tmo_q) begin
                  nn_enable_q    <= 1'b0;
                  result_valid_q <= 1'b1;
                  result_err_q   <= 1'b1;
                  result_digit_q <= 8'hFF;
                  state_q        <= S_REPORT;
               end
            end
            S_REPORT: begin
               busy_q  <= 1'b0;
               state_q <= S_LOAD;
            end
            default: begin
               state_q <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for the frame sequencer; the network is played inline by the stimulus sequence.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Every wait on the DUT is bounded, an expired bound is counted as a failed check.
module tb_nn_frame_sequencer;

   localparam int NPIX = 784;
   localparam int TMO  = 1000;

   logic              clk;
   logic              reset;
   logic signed [7:0] img [0:NPIX-1];
   logic              nn_enable;
   logic              nn_done;
   logic [7:0]        nn_digit;
   logic              result_valid;
   logic [7:0]        result_digit;
   logic              result_err;
   logic              busy;

   int errors = 0;
   int checks = 0;
   int strobes = 0;
   int en_rises = 0;
   logic en_prev = 1'b0;
   int snap;

   nn_frame_sequencer_if pix_if ();

   nn_frame_sequencer #(.NPIX(NPIX), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .pix          (pix_if),
      .img          (img),
      .nn_enable    (nn_enable),
      .nn_done      (nn_done),
      .nn_digit     (nn_digit),
      .result_valid (result_valid),
      .result_digit (result_digit),
      .result_err   (result_err),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count result strobes and enable rising edges as seen at the sampling edge.
   always @(negedge clk) begin
      if (result_valid === 1'b1) strobes++;
      if (nn_enable === 1'b1 && en_prev !== 1'b1) en_rises++;
      en_prev = nn_enable;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Test image: a vertical bar (digit "1") on a ramp background, even grey levels, one odd 255.
   function automatic logic [7:0] pix_val(input int i);
      int r;
      int c;
      r = i / 28;
      c = i % 28;
      if (i == 5) return 8'd255;
      if (r >= 4 && r <= 23 && c >= 12 && c <= 15) return 8'd254;
      return 8'(((i * 3 + r) % 128) * 2);
   endfunction

   task automatic check_img(input string tag);
      int bad;
      logic [7:0] v;
      bad = 0;
      for (int i = 0; i < NPIX; i++) begin
         v = pix_val(i);
         if (img[i] !== $signed(v >> 1)) bad++;
      end
      check(tag, bad, 0);
   endtask

   // Streams one frame; stops after pixel short_at when it is a short frame. Ends on the
   // falling edge just after the last accepting rising edge.
   task automatic send_frame(input int gap_max, input int short_at);
      int guard;
      for (int i = 0; i < NPIX; i++) begin
         if (gap_max > 0) begin
            pix_if.pix_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
         end
         pix_if.pix_valid = 1'b1;
         pix_if.pix_data  = pix_val(i);
         pix_if.pix_last  = (i == NPIX - 1) || (i == short_at);
         guard = 0;
         while (pix_if.pix_ready !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 3000) check("pix_ready_timeout", 32'(pix_if.pix_ready), 1);
         @(negedge clk);
         if (i == short_at) break;
      end
      pix_if.pix_valid = 1'b0;
      pix_if.pix_last  = 1'b0;
   endtask

   // Called at cycle N+1 after the final pixel; returns at the first cycle with enable high.
   task automatic start_run(input string tag);
      int guard;
      check({tag, "_start_en"},    32'(nn_enable), 0);
      check({tag, "_start_busy"},  32'(busy), 1);
      check({tag, "_start_ready"}, 32'(pix_if.pix_ready), 0);
      @(negedge clk);
      check({tag, "_en_n2"}, 32'(nn_enable), 1);
      guard = 0;
      while (nn_enable !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Plays the network: done rises after `delay` cycles with `digit`, then checks the report.
   task automatic done_seq(input string tag, input int delay, input logic [7:0] digit);
      int s0;
      repeat (delay) @(negedge clk);
      s0 = strobes;
      nn_digit = digit;
      nn_done  = 1'b1;
      @(negedge clk);
      check({tag, "_d1_valid"}, 32'(result_valid), 0);
      check({tag, "_d1_en"},    32'(nn_enable), 1);
      @(negedge clk);
      check({tag, "_d2_valid"}, 32'(result_valid), 1);
      check({tag, "_d2_digit"}, 32'(result_digit), 32'(digit));
      check({tag, "_d2_err"},   32'(result_err), 0);
      check({tag, "_d2_en"},    32'(nn_enable), 0);
      @(negedge clk);
      check({tag, "_d3_ready"}, 32'(pix_if.pix_ready), 1);
      check({tag, "_d3_valid"}, 32'(result_valid), 0);
      check({tag, "_d3_busy"},  32'(busy), 0);
      check({tag, "_d3_hold"},  32'(result_digit), 32'(digit));
      check({tag, "_one_strobe"}, strobes - s0, 1);
      nn_done = 1'b0;
   endtask

   initial begin
      reset            = 1'b0;
      nn_done          = 1'b0;
      nn_digit         = 8'h00;
      pix_if.pix_valid = 1'b0;
      pix_if.pix_data  = 8'h00;
      pix_if.pix_last  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_en",     32'(nn_enable), 0);
      check("rst_valid",  32'(result_valid), 0);
      check("rst_err",    32'(result_err), 0);
      check("rst_digit",  32'(result_digit), 0);
      check("rst_busy",   32'(busy), 0);
      check("rst_ready",  32'(pix_if.pix_ready), 1);
      check("rst_img0",   32'(img[0]), 0);
      check("rst_img783", 32'(img[NPIX-1]), 0);
      reset = 1'b1;
      @(negedge clk);

      // Full frame at one pixel per cycle, network answers 7 after 50 cycles
      send_frame(0, -1);
      start_run("full");
      done_seq("full", 50, 8'd7);
      check_img("full_img");

      // Same frame with random stalls gives the same image and result
      send_frame(5, -1);
      start_run("stall");
      done_seq("stall", 50, 8'd7);
      check_img("stall_img");

      // Short frame: pix_last on pixel 100 reports an error without running the network
      snap = en_rises;
      send_frame(0, 100);
      check("short_valid", 32'(result_valid), 1);
      check("short_err",   32'(result_err), 1);
      check("short_digit", 32'(result_digit), 32'hFF);
      check("short_en",    32'(nn_enable), 0);
      check("short_ready_n1", 32'(pix_if.pix_ready), 0);
      @(negedge clk);
      check("short_ready_n2", 32'(pix_if.pix_ready), 1);
      check("short_no_en", en_rises - snap, 0);
      send_frame(0, -1);
      start_run("after_short");
      done_seq("after_short", 30, 8'd2);
      check_img("after_short_img");

      // Timeout: network never answers
      send_frame(0, -1);
      start_run("tmo");
      snap = strobes;
      repeat (TMO + 1) @(negedge clk);
      check("tmo_pre_valid", 32'(result_valid), 0);
      check("tmo_pre_en",    32'(nn_enable), 1);
      @(negedge clk);
      check("tmo_valid", 32'(result_valid), 1);
      check("tmo_err",   32'(result_err), 1);
      check("tmo_digit", 32'(result_digit), 32'hFF);
      check("tmo_en",    32'(nn_enable), 0);
      @(negedge clk);
      check("tmo_ready", 32'(pix_if.pix_ready), 1);
      check("tmo_one_strobe", strobes - snap, 1);

      // Stale done: level already high before START must not be taken as completion
      nn_done  = 1'b1;
      nn_digit = 8'd9;
      send_frame(0, -1);
      start_run("stale");
      snap = strobes;
      repeat (5) @(negedge clk);
      check("stale_no_strobe", strobes - snap, 0);
      check("stale_en_held",   32'(nn_enable), 1);
      nn_done = 1'b0;
      repeat (3) @(negedge clk);
      done_seq("stale", 0, 8'd3);

      // Reset in the middle of WAIT
      send_frame(0, -1);
      start_run("rstw");
      repeat (10) @(negedge clk);
      snap = strobes;
      reset = 1'b0;
      #1;
      check("rstw_en",    32'(nn_enable), 0);
      check("rstw_digit", 32'(result_digit), 0);
      check("rstw_err",   32'(result_err), 0);
      check("rstw_busy",  32'(busy), 0);
      check("rstw_img",   32'(img[300]), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rstw_ready",     32'(pix_if.pix_ready), 1);
      check("rstw_no_strobe", strobes - snap, 0);
      send_frame(0, -1);
      start_run("post_rst");
      done_seq("post_rst", 20, 8'd4);
      check_img("post_rst_img");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
